// File: rtl/jtcop_obj_draw.sv
// Object line renderer: scans the buffered object table for the next line, fetches
// 4bpp graphics and draws them into a ping-pong line buffer played out at pixel rate.
module jtcop_obj_draw #(
    parameter int HOFFSET = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pxl_cen,
    input  logic        hs,
    input  logic [7:0]  vrender,
    input  logic [7:0]  hdump,
    output logic [9:0]  ram_addr,
    input  logic [15:0] ram_data,
    output logic        rom_cs,
    output logic [16:0] rom_addr,
    input  logic        rom_ok,
    input  logic [31:0] rom_data,
    output logic [7:0]  pxl,
    output logic        overflow
);

    typedef enum logic [3:0] {
        IDLE, READ0, READ1, READ2, CAPT, CHECK, FETCH, DRAW, NEXT
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  n_q, n_d;
    logic [7:0]  vrender_q, vrender_d;
    logic        en_q, en_d, flipy_q, flipy_d, flipx_q, flipx_d;
    logic [1:0]  size_q, size_d;
    logic [8:0]  y_q, y_d, x_q, x_d;
    logic [11:0] code_q, code_d, tile_q, tile_d;
    logic [3:0]  pal_q, pal_d, row_q, row_d;
    logic        half_q, half_d, second_q, second_d;
    logic [2:0]  k_q, k_d;
    logic [31:0] pix_q, pix_d;
    logic        rom_cs_q, rom_cs_d, wr_half_q, wr_half_d, overflow_q, overflow_d;
    logic [7:0]  pxl_q;
    logic        draw_we;

    logic [8:0]  dy, hgt, ysel, target;
    logic [3:0]  col;
    logic [7:0]  rd_addr;
    logic [7:0]  lbuf [0:511];

    // Wrapping distance from the object top; large values mean the line is above it.
    assign dy      = {1'b0, vrender_q} - y_q;
    assign hgt     = 9'd16 << size_q;
    assign ysel    = flipy_q ? (hgt - 9'd1 - dy) : dy;
    assign col     = flipx_q ? pix_q[3:0] : pix_q[31:28];
    assign target  = x_q + {5'd0, second_q, k_q};
    assign rd_addr = hdump + 8'(HOFFSET);

    assign ram_addr = {n_q, (state_q == READ1) ? 2'd1 : (state_q == READ2) ? 2'd2 : 2'd0};
    assign rom_addr = {tile_q, half_q, row_q};
    assign rom_cs   = rom_cs_q;
    assign pxl      = pxl_q;
    assign overflow = overflow_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_d    = state_q;
        n_d        = n_q;
        vrender_d  = vrender_q;
        en_d       = en_q;
        flipy_d    = flipy_q;
        flipx_d    = flipx_q;
        size_d     = size_q;
        y_d        = y_q;
        x_d        = x_q;
        code_d     = code_q;
        tile_d     = tile_q;
        pal_d      = pal_q;
        row_d      = row_q;
        half_d     = half_q;
        second_d   = second_q;
        k_d        = k_q;
        pix_d      = pix_q;
        rom_cs_d   = 1'b0;
        wr_half_d  = wr_half_q;
        overflow_d = 1'b0;
        draw_we    = 1'b0;

        case (state_q)
            READ0: state_d = READ1;
            READ1: begin
                en_d    = ram_data[15];
                flipy_d = ram_data[14];
                flipx_d = ram_data[13];
                size_d  = ram_data[10:9];
                y_d     = ram_data[8:0];
                state_d = READ2;
            end
            READ2: begin
                code_d  = ram_data[11:0];
                state_d = CAPT;
            end
            CAPT: begin
                pal_d   = ram_data[15:12];
                x_d     = ram_data[8:0];
                state_d = CHECK;
            end
            CHECK: begin
                if (en_q && dy < hgt) begin
                    tile_d   = code_q + {7'd0, ysel[8:4]};
                    row_d    = dy[3:0] ^ {4{flipy_q}};
                    half_d   = flipx_q;
                    second_d = 1'b0;
                    rom_cs_d = 1'b1;
                    state_d  = FETCH;
                end else begin
                    state_d = NEXT;
                end
            end
            FETCH: begin
                if (rom_ok && rom_cs_q) begin
                    pix_d   = rom_data;
                    k_d     = 3'd0;
                    state_d = DRAW;
                end else begin
                    rom_cs_d = 1'b1;
                end
            end
            DRAW: begin
                draw_we = (col != 4'd0) && !target[8];
                pix_d   = flipx_q ? (pix_q >> 4) : (pix_q << 4);
                k_d     = k_q + 3'd1;
                if (k_q == 3'd7) begin
                    if (!second_q) begin
                        second_d = 1'b1;
                        half_d   = ~half_q;
                        rom_cs_d = 1'b1;
                        state_d  = FETCH;
                    end else begin
                        state_d = NEXT;
                    end
                end
            end
            NEXT: begin
                if (n_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    n_d     = n_q - 8'd1;
                    state_d = READ0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line start overrides whatever the scan was doing.
        if (hs) begin
            wr_half_d  = ~wr_half_q;
            vrender_d  = vrender;
            n_d        = 8'hff;
            state_d    = READ0;
            rom_cs_d   = 1'b0;
            overflow_d = (state_q != IDLE);
            draw_we    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            n_q        <= 8'd0;
            vrender_q  <= 8'd0;
            en_q       <= 1'b0;
            flipy_q    <= 1'b0;
            flipx_q    <= 1'b0;
            size_q     <= 2'd0;
            y_q        <= 9'd0;
            x_q        <= 9'd0;
            code_q     <= 12'd0;
            tile_q     <= 12'd0;
            pal_q      <= 4'd0;
            row_q      <= 4'd0;
            half_q     <= 1'b0;
            second_q   <= 1'b0;
            k_q        <= 3'd0;
            pix_q      <= 32'd0;
            rom_cs_q   <= 1'b0;
            wr_half_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q    <= state_d;
            n_q        <= n_d;
            vrender_q  <= vrender_d;
            en_q       <= en_d;
            flipy_q    <= flipy_d;
            flipx_q    <= flipx_d;
            size_q     <= size_d;
            y_q        <= y_d;
            x_q        <= x_d;
            code_q     <= code_d;
            tile_q     <= tile_d;
            pal_q      <= pal_d;
            row_q      <= row_d;
            half_q     <= half_d;
            second_q   <= second_d;
            k_q        <= k_d;
            pix_q      <= pix_d;
            rom_cs_q   <= rom_cs_d;
            wr_half_q  <= wr_half_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: the line buffer is not reset; playout clears each location as it is read.
    always_ff @(posedge clk) begin
        if (draw_we) lbuf[{wr_half_q, target[7:0]}] <= {pal_q, col};
        if (pxl_cen) lbuf[{~wr_half_q, rd_addr}] <= 8'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pxl_q <= 8'd0;
        end else if (pxl_cen) begin
            pxl_q <= lbuf[{~wr_half_q, rd_addr}];
        end
    end

endmodule

// File: tb/tb_jtcop_obj_draw.sv
// Directed bench for jtcop_obj_draw: object table and ROM models, line playout checks.
module tb_jtcop_obj_draw;

    logic        clk = 1'b0;
    logic        rst, pxl_cen, hs;
    logic [7:0]  vrender, hdump;
    logic [9:0]  ram_addr;
    logic [15:0] ram_data;
    logic        rom_cs, rom_ok;
    logic [16:0] rom_addr;
    logic [31:0] rom_data;
    logic [7:0]  pxl;
    logic        overflow;

    jtcop_obj_draw #(.HOFFSET(0)) dut (
        .clk      (clk),
        .rst      (rst),
        .pxl_cen  (pxl_cen),
        .hs       (hs),
        .vrender  (vrender),
        .hdump    (hdump),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .rom_cs   (rom_cs),
        .rom_addr (rom_addr),
        .rom_ok   (rom_ok),
        .rom_data (rom_data),
        .pxl      (pxl),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Object buffer with one-clock read latency.
    logic [15:0] mem [0:1023];
    always @(posedge clk) ram_data <= mem[ram_addr];

    // Graphics ROM: data chosen by half bit, answers one clock after the request.
    logic [31:0] rom_h0, rom_h1;
    logic        rom_en;
    always @(posedge clk) begin
        rom_ok   <= rom_cs && rom_en;
        rom_data <= rom_addr[4] ? rom_h1 : rom_h0;
    end

    int          fetch_n = 0;
    int          ovf_n = 0;
    int          cs_n = 0;
    logic        clr_cnt = 1'b0;
    logic [16:0] fetch_log [0:15];
    always @(posedge clk) begin
        if (clr_cnt) fetch_n <= 0;
        else if (rom_cs && rom_ok) begin
            if (fetch_n < 16) fetch_log[fetch_n] <= rom_addr;
            fetch_n <= fetch_n + 1;
        end
        if (overflow) ovf_n <= ovf_n + 1;
        if (rom_cs) cs_n <= cs_n + 1;
    end

    logic [7:0] got [0:255];

    function automatic logic [15:0] mk_w0(input logic en, input logic fy, input logic fx,
                                          input logic [1:0] size, input logic [8:0] y);
        return {en, fy, fx, 2'b00, size, y};
    endfunction

    function automatic logic [15:0] mk_w2(input logic [3:0] pal, input logic [8:0] x);
        return {pal, 3'b000, x};
    endfunction

    task automatic clear_table();
        for (int i = 0; i < 1024; i++) mem[i] = 16'd0;
    endtask

    task automatic set_entry(input int n, input logic [15:0] w0, input logic [15:0] w1,
                             input logic [15:0] w2);
        mem[4*n]   = w0;
        mem[4*n+1] = w1;
        mem[4*n+2] = w2;
    endtask

    task automatic pulse_hs(input logic [7:0] v);
        @(negedge clk);
        vrender = v;
        hs = 1'b1;
        @(negedge clk);
        hs = 1'b0;
    endtask

    task automatic readout();
        for (int h = 0; h <= 256; h++) begin
            @(negedge clk);
            if (h > 0) got[h-1] = pxl;
            hdump   = h[7:0];
            pxl_cen = (h < 256);
        end
        pxl_cen = 1'b0;
    endtask

    // Render one line from the current table, then display it with an empty table.
    task automatic run_line(input logic [7:0] v);
        @(negedge clk) clr_cnt = 1'b1;
        @(negedge clk) clr_cnt = 1'b0;
        pulse_hs(v);
        repeat (2000) @(negedge clk);
        clear_table();
        pulse_hs(8'd0);
        readout();
        repeat (1800) @(negedge clk);
    endtask

    initial begin
        int nz;
        rst = 1'b1; pxl_cen = 1'b0; hs = 1'b0; vrender = 8'd0; hdump = 8'd0;
        rom_en = 1'b1; rom_h0 = 32'd0; rom_h1 = 32'd0;
        clear_table();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_pxl", pxl, 8'h00);
        check("rst_rom_cs", rom_cs, 1'b0);
        check("rst_ram_addr", ram_addr, 10'd0);
        check("rst_overflow", overflow, 1'b0);

        nz = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (i > 256 && pxl != 8'h00) nz++;
            hdump   = i[7:0];
            pxl_cen = 1'b1;
        end
        @(negedge clk) pxl_cen = 1'b0;
        check("idle_pxl_nonzero", nz, 0);
        check("idle_rom_cs", cs_n, 0);

        // Plain 16x16 object.
        set_entry(0, mk_w0(1, 0, 0, 2'd0, 9'd10), 16'h0123, mk_w2(4'd5, 9'd20));
        rom_h0 = 32'h12345678; rom_h1 = 32'h12345678;
        run_line(8'd12);
        check("t1_fetches", fetch_n, 2);
        check("t1_addr0", fetch_log[0], {12'h123, 1'b0, 4'd2});
        check("t1_addr1", fetch_log[1], {12'h123, 1'b1, 4'd2});
        for (int i = 0; i < 8; i++) check($sformatf("t1_col%0d", 20 + i), got[20+i], 8'h51 + i[7:0]);
        check("t1_col28", got[28], 8'h51);
        check("t1_col19", got[19], 8'h00);

        // Horizontal flip: only pixel 7 of half 0 is opaque.
        set_entry(0, mk_w0(1, 0, 1, 2'd0, 9'd10), 16'h0123, mk_w2(4'd5, 9'd20));
        rom_h0 = 32'h0000000F; rom_h1 = 32'h00000000;
        run_line(8'd12);
        check("t2_addr0", fetch_log[0], {12'h123, 1'b1, 4'd2});
        check("t2_addr1", fetch_log[1], {12'h123, 1'b0, 4'd2});
        check("t2_col28", got[28], 8'h5F);
        nz = 0;
        for (int i = 0; i < 256; i++) if (i != 28 && got[i] != 8'h00) nz++;
        check("t2_other_cols", nz, 0);

        // 16x32 vertically flipped object hanging off the right edge.
        set_entry(0, mk_w0(1, 1, 0, 2'd1, 9'd0), 16'h0040, mk_w2(4'd3, 9'd250));
        rom_h0 = 32'h11111111; rom_h1 = 32'h11111111;
        run_line(8'd3);
        check("t3a_addr0", fetch_log[0], {12'h041, 1'b0, 4'd12});
        check("t3a_col250", got[250], 8'h31);
        check("t3a_col255", got[255], 8'h31);
        check("t3a_col0", got[0], 8'h00);
        check("t3a_col2", got[2], 8'h00);
        set_entry(0, mk_w0(1, 1, 0, 2'd1, 9'd0), 16'h0040, mk_w2(4'd3, 9'd250));
        run_line(8'd20);
        check("t3b_addr0", fetch_log[0], {12'h040, 1'b0, 4'd11});

        // Overlap: entry 0 on top of entry 1.
        set_entry(0, mk_w0(1, 0, 0, 2'd0, 9'd10), 16'h0123, mk_w2(4'd7, 9'd40));
        set_entry(1, mk_w0(1, 0, 0, 2'd0, 9'd10), 16'h0200, mk_w2(4'd2, 9'd40));
        rom_h0 = 32'h12345678; rom_h1 = 32'h12345678;
        run_line(8'd12);
        check("t4_fetches", fetch_n, 4);
        check("t4_col40", got[40], 8'h71);
        check("t4_col47", got[47], 8'h78);
        set_entry(0, mk_w0(1, 0, 0, 2'd0, 9'd10), 16'h0123, mk_w2(4'd7, 9'd40));
        set_entry(1, mk_w0(0, 0, 0, 2'd0, 9'd10), 16'h0200, mk_w2(4'd2, 9'd40));
        run_line(8'd12);
        check("t4_disabled_fetches", fetch_n, 2);
        check("t4_disabled_col40", got[40], 8'h71);

        // Stalled ROM, then a line start aborts the scan.
        check("no_overflow_yet", ovf_n, 0);
        clear_table();
        set_entry(255, mk_w0(1, 0, 0, 2'd0, 9'd10), 16'h0123, mk_w2(4'd5, 9'd20));
        rom_en = 1'b0;
        pulse_hs(8'd12);
        repeat (5000) @(negedge clk);
        check("t5_stall_cs", rom_cs, 1'b1);
        check("t5_stall_addr", rom_addr, {12'h123, 1'b0, 4'd2});
        hs = 1'b1;
        @(negedge clk) hs = 1'b0;
        check("t5_overflow", overflow, 1'b1);
        check("t5_cs_drop", rom_cs, 1'b0);
        check("t5_read0_addr", ram_addr, 10'd1020);
        @(negedge clk);
        check("t5_overflow_end", overflow, 1'b0);
        check("t5_read1_addr", ram_addr, 10'd1021);
        repeat (10) @(negedge clk);
        check("t5_overflow_count", ovf_n, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jtcop_obj_draw.md
Name: jtcop_obj_draw

Overview:
- Object line renderer, directly downstream of the object double buffer.
- Each line it scans the buffered 256-entry object table, selects objects intersecting the next line and fetches their 4bpp graphics from ROM.
- Writes those pixels into a ping-pong line buffer; the other half is played out at pixel rate as `pxl` for the colour mixer.

Parameters:
- `HOFFSET`, 0, signed added to `hdump` when reading the display line buffer (alignment trim).

Ports:
- `clk`       in   1   system clock
- `rst`       in   1   synchronous, active-high reset
- `pxl_cen`   in   1   pixel clock enable
- `hs`        in   1   line start strobe, one clk wide
- `vrender`   in   8   line being prepared (next displayed line)
- `hdump`     in   8   current displayed pixel column
- `ram_addr`  out  10  object buffer read address, word units
- `ram_data`  in   16  object buffer data; valid 1 clk after `ram_addr`
- `rom_cs`    out  1   graphics ROM request
- `rom_addr`  out  17  `{tile[11:0], half, row[3:0]}`, 32-bit words
- `rom_ok`    in   1   ROM data valid
- `rom_data`  in   32  8 pixels × 4 bits, pixel 0 in [31:28]
- `pxl`       out  8   `{pal[3:0], col[3:0]}`; `col==0` is transparent
- `overflow`  out  1   pulse: line scan aborted by `hs` before completion

Behaviour:
- Entry n occupies words `4n..4n+3`; word 3 is ignored.
  - w0: [15] enable, [14] flipy, [13] flipx, [10:9] size (height = 16<<size px), [8:0] y.
  - w1: [11:0] code.
  - w2: [15:12] pal, [8:0] x.
- Reset: `pxl`=0, `rom_cs`=0, `ram_addr`=0, `overflow`=0, FSM=IDLE, write-half select=0. Line buffer contents are undefined until the first cleared pass.
- On `hs`: toggle the write/read halves, latch `vrender`, set entry n=255, enter READ0. This applies from any state; an active ROM request is dropped (`rom_cs`→0). If the FSM was not IDLE, pulse `overflow` for 1 clk.
- FSM:
  - READ0/READ1/READ2 issue `ram_addr`=4n+0/1/2 on successive clks. Data is captured one clk later, so CHECK occurs 4 clks after READ0.
  - CHECK: compute `dy = {1'b0,vrender} - y`, 9-bit wrapping.
    - Hit if enable=1 and `dy < (16<<size)`.
    - Miss → NEXT.
    - Hit: `tile = code + ((flipy ? (hgt-1-dy) : dy) >> 4)`, truncated to 12 bits; `row = dy[3:0] ^ {4{flipy}}`; half = flipx. Go to FETCH.
  - FETCH: `rom_cs`=1, `rom_addr` held stable until `rom_ok`=1 with `rom_cs`=1. Capture `rom_data`, drop `rom_cs` the next clk, go to DRAW.
  - DRAW: 8 clks, one pixel per clk. Order is pixel 0..7, or 7..0 when flipx.
    - Target column = x + 8·(second-half index) + k, 9 bits.
    - Write skipped if col==0 or target ≥ 256.
    - After the first half, toggle half and FETCH again; after the second half, go to NEXT.
  - NEXT: if n==0 → IDLE, else n−1 → READ0.
- Priority: scan order is 255→0, so lower entries overwrite higher ones (entry 0 on top).
- Playout: on each `pxl_cen`, `pxl` ← readbuf[`hdump`+`HOFFSET`] (8-bit wrap). That location is cleared to 0 in the same cycle. Latency: 1 `pxl_cen` after `hdump` changes.
- Line buffers are 2×256×8 bit. A write and a read never target the same half.
- `hs` coincident with a DRAW write: the write is discarded.

Test Plan:
- Reset, no `hs`: `pxl`=0 for 1000 `pxl_cen`; `rom_cs` never asserted.
- Entry 0: y=10, x=20, code=0x123, size=0, pal=5, no flips; `vrender`=12; `rom_data`=0x12345678.
  - Expect `rom_addr`={0x123,0,4'd2} then {0x123,1,4'd2}.
  - Next line `pxl` at hdump 20..27 = 0x51..0x58.
- Same entry with flipx: first fetch half=1; pixel order reversed; `rom_data`=0x0000000F → only column 20+8 gets col F (`pxl`=0x5F); zero pixels leave the background unchanged.
- Size=1, flipy, y=0, `vrender`=3: tile=code+1, row=12; `vrender`=20: tile=code, row=11. x=250: columns ≥256 not written, 250..255 drawn.
- Entries 0 and 1 overlap at the same x: the entry 0 colour wins. Entry 1 with enable=0 produces no ROM request.
- `rom_ok` held low for 5000 clks, then `hs`: `overflow` pulses once, `rom_cs` drops. The new line starts at entry 255, READ0, addr 1020.
